// File: rtl/sdram_pkg.sv
// sdram_pkg: command/state enums and default timing shared by the SDRAM arbiter slice.
package sdram_pkg;
    typedef enum logic [1:0] {CMD_NOP = 2'd0, CMD_REFRESH = 2'd1, CMD_READ = 2'd2, CMD_WRITE = 2'd3} cmd_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;
    localparam int REF_PERIOD_DEF = 780;
    localparam int STARVE_LIM_DEF = 4;
endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: requester handshakes and controller command bus around the arbiter.
interface sdram_arbiter_if #(parameter int ADDR_W = 22);
    import sdram_pkg::*;
    logic              rd_req, rd_grant, rd_done;
    logic              wr_req, wr_grant, wr_done;
    logic              cmd_valid, cmd_ready, cmd_done;
    logic [ADDR_W-1:0] rd_addr, wr_addr, cmd_addr;
    cmd_t              cmd_type;
    modport master(
        input  rd_req, rd_addr, wr_req, wr_addr, cmd_ready, cmd_done,
        output rd_grant, rd_done, wr_grant, wr_done, cmd_valid, cmd_type, cmd_addr
    );
    modport slave(
        output rd_req, rd_addr, wr_req, wr_addr, cmd_ready, cmd_done,
        input  rd_grant, rd_done, wr_grant, wr_done, cmd_valid, cmd_type, cmd_addr
    );
endinterface

// File: rtl/sdram_ref_timer.sv
// sdram_ref_timer: auto-refresh period counter with pending flag and sticky overrun.
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int REF_PERIOD = REF_PERIOD_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic ref_ack,
    output logic ref_pend,
    output logic ref_overrun
);
    localparam int CW = $clog2(REF_PERIOD);
    logic [CW-1:0] cnt;
    logic          wrap;
    assign wrap = en && cnt == CW'(REF_PERIOD - 1);
    // A new period always re-arms pend; only one refresh is ever owed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt         <= '0;
            ref_pend    <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            if (en) cnt <= wrap ? '0 : cnt + 1'b1;
            ref_pend    <= wrap | (ref_pend & ~ref_ack);
            ref_overrun <= ref_overrun | (wrap & ref_pend);
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: one-at-a-time REFRESH > READ > WRITE arbitration for the SDRAM controller.
// ARB_STARVE_GUARD_EN: lets a waiting write outrank reads after STARVE_LIM read grants.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W     = 22,
    parameter int REF_PERIOD = REF_PERIOD_DEF
`ifdef ARB_STARVE_GUARD_EN
    , parameter int STARVE_LIM = STARVE_LIM_DEF
`endif
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            init_done,
    sdram_arbiter_if.master bus,
    output logic            ref_overrun
);
    state_t            state, state_nx;
    cmd_t              cur, cur_nx;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic              ref_pend, accept, wr_first;

    assign accept = state == S_ISSUE && bus.cmd_ready;

    sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_ref (
        .CLK, .RST,
        .en(init_done),
        .ref_ack(accept && cur == CMD_REFRESH),
        .ref_pend,
        .ref_overrun
    );

`ifdef ARB_STARVE_GUARD_EN
    logic [$clog2(STARVE_LIM + 1)-1:0] starve;
    always_ff @(posedge CLK) begin
        if (RST) starve <= '0;
        else if (bus.wr_grant) starve <= '0;
        else if (bus.rd_grant && bus.wr_req && starve != STARVE_LIM) starve <= starve + 1'b1;
    end
    assign wr_first = bus.wr_req && starve == STARVE_LIM;
`else
    assign wr_first = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            cur   <= CMD_NOP;
            addr  <= '0;
        end else begin
            state <= state_nx;
            cur   <= cur_nx;
            addr  <= addr_nx;
        end
    end

    // Type and address are frozen at the IDLE decision so the command stays stable while offered.
    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        addr_nx  = addr;
        case (state)
            S_IDLE: if (init_done && (ref_pend || bus.rd_req || bus.wr_req)) begin
                state_nx = S_ISSUE;
                cur_nx   = ref_pend ? CMD_REFRESH : (bus.rd_req && !wr_first) ? CMD_READ : CMD_WRITE;
                addr_nx  = cur_nx == CMD_READ ? bus.rd_addr : cur_nx == CMD_WRITE ? bus.wr_addr : '0;
            end
            S_ISSUE: if (bus.cmd_ready) state_nx = S_BUSY;
            S_BUSY:  if (bus.cmd_done) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.cmd_valid = state == S_ISSUE;
    assign bus.cmd_type  = bus.cmd_valid ? cur : CMD_NOP;
    assign bus.cmd_addr  = bus.cmd_valid ? addr : '0;
    assign bus.rd_grant  = accept && cur == CMD_READ;
    assign bus.wr_grant  = accept && cur == CMD_WRITE;
    assign bus.rd_done   = state == S_BUSY && bus.cmd_done && cur == CMD_READ;
    assign bus.wr_done   = state == S_BUSY && bus.cmd_done && cur == CMD_WRITE;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_sdram_arbiter;
    import sdram_pkg::*;
    localparam int AW = 22;
    localparam int RP = REF_PERIOD_DEF;
    localparam int SL = STARVE_LIM_DEF;

    logic CLK = 1'b0, RST = 1'b1, init_done = 1'b0, ref_overrun;
    sdram_arbiter_if #(.ADDR_W(AW)) bus();
    sdram_arbiter #(.ADDR_W(AW)) dut (.CLK(CLK), .RST(RST), .init_done(init_done), .bus(bus), .ref_overrun(ref_overrun));
    always #5 CLK = ~CLK;

    int vectors = 0, miscompares = 0, cyc = 0;
    int tcnt, starve, done_cnt, lat = 2, ready_pct = 100, obs_valid = 0, c0, n_wr;
    bit pend, ovr, offering, waiting, free, withhold = 0, spur = 0, exp_rd_g, exp_wr_g;
    cmd_t otype;
    logic [AW-1:0] oaddr;
    cmd_t seq[$];
    cmd_t data_seq[$];
    logic [AW-1:0] seq_addr[$];
    int ref_at[$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        tcnt = 0; starve = 0; done_cnt = 0;
        pend = 0; ovr = 0; offering = 0; waiting = 0; free = 1;
    endtask

    // One clock: drive the controller side, check outputs, advance the model across the edge.
    task automatic step();
        bit wrap, acc, wf;
        done_cnt = waiting ? done_cnt + 1 : 0;
        bus.cmd_ready = $urandom_range(99) < ready_pct;
        bus.cmd_done = waiting ? (!withhold && done_cnt >= lat) : (spur && $urandom_range(7) == 0);
        #1;
        exp_rd_g = 0;
        exp_wr_g = 0;
        if (RST) model_reset();
        else begin
            acc = offering && bus.cmd_ready;
            exp_rd_g = acc && otype == CMD_READ;
            exp_wr_g = acc && otype == CMD_WRITE;
            check("cmd_valid", bus.cmd_valid, offering);
            check("cmd_type", bus.cmd_type, offering ? otype : CMD_NOP);
            check("cmd_addr", bus.cmd_addr, offering ? oaddr : '0);
            check("rd_grant", bus.rd_grant, exp_rd_g);
            check("wr_grant", bus.wr_grant, exp_wr_g);
            check("rd_done", bus.rd_done, waiting && bus.cmd_done && otype == CMD_READ);
            check("wr_done", bus.wr_done, waiting && bus.cmd_done && otype == CMD_WRITE);
            check("ref_overrun", ref_overrun, ovr);
            if (bus.cmd_valid) obs_valid++;
            if (bus.cmd_valid && bus.cmd_ready) begin
                seq.push_back(bus.cmd_type);
                seq_addr.push_back(bus.cmd_addr);
                if (bus.cmd_type == CMD_REFRESH) ref_at.push_back(cyc);
                else data_seq.push_back(bus.cmd_type);
            end
            wrap = 0;
            if (init_done) begin
                tcnt++;
                if (tcnt == RP) begin tcnt = 0; wrap = 1; end
            end
            if (wrap && pend) ovr = 1;
            if (free) begin
`ifdef ARB_STARVE_GUARD_EN
                wf = bus.wr_req && starve >= SL;
`else
                wf = 0;
`endif
                if (init_done && (pend || bus.rd_req || bus.wr_req)) begin
                    if (pend) begin otype = CMD_REFRESH; oaddr = '0; end
                    else if (wf || !bus.rd_req) begin otype = CMD_WRITE; oaddr = bus.wr_addr; end
                    else begin otype = CMD_READ; oaddr = bus.rd_addr; end
                    offering = 1;
                    free = 0;
                end
            end else if (acc) begin
                offering = 0;
                waiting = 1;
                if (otype == CMD_READ && bus.wr_req && starve < SL) starve++;
                if (otype == CMD_WRITE) starve = 0;
            end else if (waiting && bus.cmd_done) begin
                waiting = 0;
                free = 1;
            end
            pend = wrap || (pend && !(acc && otype == CMD_REFRESH));
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic wait_seq(string tag, int n, int lim);
        for (int i = 0; i < lim && seq.size() < n; i++) step();
        check(tag, seq.size(), n);
    endtask

    task automatic reset_seq();
        RST = 1;
        run(2);
        RST = 0;
        seq.delete(); seq_addr.delete(); ref_at.delete(); data_seq.delete();
    endtask

    initial begin
        bus.rd_req = 0; bus.wr_req = 0; bus.rd_addr = '0; bus.wr_addr = '0;
        bus.cmd_ready = 0; bus.cmd_done = 0;
        model_reset();
        @(posedge CLK);
        #1;
        reset_seq();
        check("rst_valid", bus.cmd_valid, 0);
        check("rst_type", bus.cmd_type, CMD_NOP);
        check("rst_overrun", ref_overrun, 0);

        // No activity of any kind before init completes
        bus.rd_req = 1; bus.wr_req = 1;
        obs_valid = 0;
        run(2000);
        check("pre_init_valid", obs_valid, 0);

        // Refresh cadence with nothing else requested
        reset_seq();
        bus.rd_req = 0; bus.wr_req = 0;
        init_done = 1;
        c0 = cyc;
        run(3 * RP + 20);
        check("ref_count", ref_at.size(), 3);
        if (ref_at.size() > 0) check("ref_first", ref_at[0] - c0, RP + 1);
        for (int i = 1; i < ref_at.size(); i++) check("ref_period", ref_at[i] - ref_at[i-1], RP);

        // Simultaneous requests: read first, write after completion
        seq.delete(); seq_addr.delete();
        bus.rd_addr = 22'h12345; bus.wr_addr = 22'h2abcd;
        bus.rd_req = 1; bus.wr_req = 1;
        wait_seq("rd_first_wait", 1, 20);
        bus.rd_req = 0;
        wait_seq("wr_next_wait", 2, 20);
        bus.wr_req = 0;
        if (seq.size() >= 2) begin
            check("first_type", seq[0], CMD_READ);
            check("first_addr", seq_addr[0], 22'h12345);
            check("second_type", seq[1], CMD_WRITE);
            check("second_addr", seq_addr[1], 22'h2abcd);
        end

        // Refresh arriving during a stalled READ does not preempt it
        reset_seq();
        run(750);
        ready_pct = 0;
        bus.rd_req = 1;
        run(50);
        check("held_valid", bus.cmd_valid, 1);
        check("held_type", bus.cmd_type, CMD_READ);
        ready_pct = 100;
        wait_seq("held_acc", 1, 5);
        bus.rd_req = 0;
        wait_seq("ref_after", 2, 10);
        if (seq.size() >= 2) begin
            check("held_seq0", seq[0], CMD_READ);
            check("held_seq1", seq[1], CMD_REFRESH);
        end

        // Overrun while a burst never completes; sticky until reset
        reset_seq();
        withhold = 1;
        bus.rd_req = 1;
        wait_seq("ovr_acc", 1, 5);
        bus.rd_req = 0;
        run(1600);
        check("overrun_set", ref_overrun, 1);
        withhold = 0;
        run(100);
        check("overrun_sticky", ref_overrun, 1);
        RST = 1;
        step();
        RST = 0;
        check("overrun_clr", ref_overrun, 0);

        // Both requesters saturated
        reset_seq();
        bus.rd_req = 1; bus.wr_req = 1;
        ready_pct = 70;
        run(1200);
        n_wr = 0;
        foreach (data_seq[i]) if (data_seq[i] == CMD_WRITE) n_wr++;
`ifdef ARB_STARVE_GUARD_EN
        check("sat_len", data_seq.size() >= 10, 1);
        for (int i = 0; i < 10 && i < data_seq.size(); i++)
            check("sat_pattern", data_seq[i], (i % 5 == 4) ? CMD_WRITE : CMD_READ);
`else
        check("sat_no_write", n_wr, 0);
`endif

        // Randomized traffic, init drops, spurious done/ready, occasional reset
        spur = 1;
        ready_pct = 60;
        for (int i = 0; i < 20000; i++) begin
            RST = $urandom_range(2999) == 0;
            if ($urandom_range(499) == 0) init_done = ~init_done;
            if (!waiting) lat = $urandom_range(4, 1);
            if (exp_rd_g) bus.rd_req = $urandom_range(1);
            else if (!bus.rd_req && $urandom_range(3) == 0) begin bus.rd_req = 1; bus.rd_addr = AW'($urandom); end
            if (exp_wr_g) bus.wr_req = $urandom_range(1);
            else if (!bus.wr_req && $urandom_range(3) == 0) begin bus.wr_req = 1; bus.wr_addr = AW'($urandom); end
            step();
        end
        RST = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
